// File: rtl/booth_sequencer_pkg.sv
// rtl/booth_sequencer_pkg.sv - shared types and Booth pair decode for the booth_sequencer block
package booth_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, ITER, DONE} state_t;

   typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_t;

   // {Q[0], Q_1} = 10 starts a run of ones (subtract), 01 ends one (add)
   function automatic booth_op_t decode_booth_pair(input logic q0, input logic q_1);
      case ({q0, q_1})
         2'b10:   return BOOTH_SUB;
         2'b01:   return BOOTH_ADD;
         default: return BOOTH_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_sequencer_if.sv
// rtl/booth_sequencer_if.sv - Start/Ready/Done operand and product bundle for booth_sequencer
interface booth_sequencer_if #(
   parameter int NBits = 16
);

   logic                   Start;
   logic [NBits-1:0]       Multiplicand;
   logic [NBits-1:0]       Multiplier;
   logic                   Ready;
   logic                   Done;
   logic [2*NBits-1:0]     Product;

   modport master (
      output Start, Multiplicand, Multiplier,
      input  Ready, Done, Product
   );

   modport slave (
      input  Start, Multiplicand, Multiplier,
      output Ready, Done, Product
   );

endinterface

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational Booth add/subtract-and-arithmetic-shift step
module booth_step
   import booth_pkg::*;
#(
   parameter int NBits = 16
) (
   input  logic [NBits:0]   a_in,
   input  logic [NBits-1:0] q_in,
   input  logic             q1_in,
   input  logic [NBits:0]   m_in,
   output logic [NBits:0]   a_out,
   output logic [NBits-1:0] q_out,
   output logic             q1_out
);

   booth_op_t        op;
   logic [NBits:0]   m_neg;
   logic [NBits:0]   addend;
   logic [NBits:0]   sum;
   logic [NBits:0]   a_src;

   // A carries a guard bit, so negating the most negative M still fits
   always_comb begin
      op    = decode_booth_pair(q_in[0], q1_in);
      m_neg = -m_in;
      sum   = a_in + addend;
   end

   Multiplexer2to1 #(.NBits(NBits + 1)) u_addend_mux (
      .sel     (op == BOOTH_SUB),
      .in0     (m_in),
      .in1     (m_neg),
      .mux_out (addend)
   );

   Multiplexer2to1 #(.NBits(NBits + 1)) u_src_mux (
      .sel     (op != BOOTH_NOP),
      .in0     (a_in),
      .in1     (sum),
      .mux_out (a_src)
   );

   // arithmetic shift right of {A, Q, Q_1}: A's sign bit is replicated
   always_comb begin
      a_out  = {a_src[NBits], a_src[NBits:1]};
      q_out  = {a_src[0], q_in[NBits-1:1]};
      q1_out = q_in[0];
   end

endmodule

// File: rtl/multiplexer2to1.sv
// rtl/multiplexer2to1.sv - parameterised two-input word multiplexer
module Multiplexer2to1 #(
   parameter int NBits = 16
) (
   input  logic             sel,
   input  logic [NBits-1:0] in0,
   input  logic [NBits-1:0] in1,
   output logic [NBits-1:0] mux_out
);

   // pass in1 when sel is set, otherwise in0
   always_comb begin
      mux_out = sel ? in1 : in0;
   end

endmodule

// File: rtl/booth_sequencer.sv
// rtl/booth_sequencer.sv - sequential radix-2 Booth signed multiplier (optional BOOTH_ZERO_SKIP_EN)
module booth_sequencer
   import booth_pkg::*;
#(
   parameter int NBits = 16
) (
   input  logic              clk,
   input  logic              reset,
   booth_sequencer_if.slave  bus
);

   localparam int CW = $clog2(NBits + 1);

   state_t               state_q, state_d;
   logic [NBits-1:0]     mcand_q, mcand_d;
   logic [NBits-1:0]     mplier_q, mplier_d;
   logic [NBits:0]       m_q, m_d;
   logic [NBits:0]       a_q, a_d;
   logic [NBits-1:0]     q_q, q_d;
   logic                 q1_q, q1_d;
   logic [CW-1:0]        count_q, count_d;
   logic [2*NBits-1:0]   product_q, product_d;
   logic                 done_q, done_d;

   logic [NBits:0]       a_step;
   logic [NBits-1:0]     q_step;
   logic                 q1_step;

   booth_step #(.NBits(NBits)) u_step (
      .a_in   (a_q),
      .q_in   (q_q),
      .q1_in  (q1_q),
      .m_in   (m_q),
      .a_out  (a_step),
      .q_out  (q_step),
      .q1_out (q1_step)
   );

   // next-state and datapath load selection; Done is set on the edge entering DONE
   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      m_d       = m_q;
      a_d       = a_q;
      q_d       = q_q;
      q1_d      = q1_q;
      count_d   = count_q;
      product_d = product_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.Start) begin
               mcand_d  = bus.Multiplicand;
               mplier_d = bus.Multiplier;
               state_d  = LOAD;
            end
         end
         LOAD: begin
            a_d     = '0;
            q_d     = mplier_q;
            q1_d    = 1'b0;
            m_d     = {mcand_q[NBits-1], mcand_q};
            count_d = CW'(NBits);
            state_d = ITER;
`ifdef BOOTH_ZERO_SKIP_EN
            if ((mcand_q == '0) || (mplier_q == '0)) begin
               product_d = '0;
               done_d    = 1'b1;
               state_d   = DONE;
            end
`endif
         end
         ITER: begin
            a_d     = a_step;
            q_d     = q_step;
            q1_d    = q1_step;
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
               product_d = {a_step[NBits-1:0], q_step};
               done_d    = 1'b1;
               state_d   = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // state and datapath registers; reset aborts any operation in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         m_q       <= '0;
         a_q       <= '0;
         q_q       <= '0;
         q1_q      <= 1'b0;
         count_q   <= '0;
         product_q <= '0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         m_q       <= m_d;
         a_q       <= a_d;
         q_q       <= q_d;
         q1_q      <= q1_d;
         count_q   <= count_d;
         product_q <= product_d;
         done_q    <= done_d;
      end
   end

   assign bus.Ready   = (state_q == IDLE);
   assign bus.Done    = done_q;
   assign bus.Product = product_q;

endmodule

// File: tb/tb_booth_sequencer.sv
// tb/tb_booth_sequencer.sv - self-checking bench for booth_sequencer at NBits=8 and NBits=16
module tb_booth_sequencer;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;

`ifdef BOOTH_ZERO_SKIP_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   booth_sequencer_if #(.NBits(8))  b8();
   booth_sequencer_if #(.NBits(16)) b16();

   booth_sequencer #(.NBits(8)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (b8)
   );

   booth_sequencer #(.NBits(16)) dut16 (
      .clk   (clk),
      .reset (reset),
      .bus   (b16)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint m;
      longint q;
      longint exp_p;
      int     exp_lat;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic int exp_lat(input bit w16, input longint m, input longint q);
      if (ZS && (m == 0 || q == 0)) return 2;
      return w16 ? 18 : 10;
   endfunction

   task automatic drive(input bit w16, input bit s, input longint m, input longint q);
      if (w16) begin
         b16.Start        = s;
         b16.Multiplicand = m[15:0];
         b16.Multiplier   = q[15:0];
      end else begin
         b8.Start         = s;
         b8.Multiplicand  = m[7:0];
         b8.Multiplier    = q[7:0];
      end
   endtask

   function automatic longint get_ready(input bit w16);
      return w16 ? longint'(b16.Ready) : longint'(b8.Ready);
   endfunction

   function automatic logic get_done(input bit w16);
      return w16 ? b16.Done : b8.Done;
   endfunction

   function automatic longint get_prod(input bit w16);
      if (w16) return longint'($signed(b16.Product));
      return longint'($signed(b8.Product));
   endfunction

   // one operation; poke_at > 0 issues a stray Start pulse at that cycle
   task automatic run_op(input bit w16, input longint m, input longint q, input int poke_at,
                         output longint prod, output int lat);
      @(negedge clk);
      check("ready_before_start", get_ready(w16), 1);
      drive(w16, 1'b1, m, q);
      @(negedge clk);
      lat = 1;
      drive(w16, 1'b0, ~m, ~q);
      check("ready_low_cycle1", get_ready(w16), 0);
      while (!get_done(w16) && lat < 40) begin
         @(negedge clk);
         lat++;
         if (lat == poke_at) drive(w16, 1'b1, 11, 22);
         else drive(w16, 1'b0, ~m, ~q);
      end
      prod = get_prod(w16);
      check("ready_low_at_done", get_ready(w16), 0);
      @(negedge clk);
      check("done_one_cycle", longint'(get_done(w16)), 0);
      check("ready_after_done", get_ready(w16), 1);
      check("product_hold", get_prod(w16), prod);
   endtask

   initial begin
      bit     w;
      longint m, q, p;
      int     lat, r, sel, ndone, last;

      vecs[0] = '{7, 3, 21, 0};
      vecs[1] = '{-128, -128, 16384, 0};
      vecs[2] = '{-128, 127, -16256, 0};
      vecs[3] = '{3, -4, -12, 0};
      vecs[4] = '{0, -77, 0, 0};
      vecs[5] = '{5, 6, 30, 0};
      vecs[6] = '{127, 127, 16129, 0};
      vecs[7] = '{-1, -1, 1, 0};
      foreach (vecs[i]) vecs[i].exp_lat = exp_lat(1'b0, vecs[i].m, vecs[i].q);

      reset = 1'b0;
      drive(1'b0, 1'b0, 0, 0);
      drive(1'b1, 1'b0, 0, 0);
      repeat (3) @(negedge clk);
      check("rst_ready8", get_ready(1'b0), 1);
      check("rst_done8", longint'(b8.Done), 0);
      check("rst_prod8", get_prod(1'b0), 0);
      check("rst_ready16", get_ready(1'b1), 1);
      check("rst_done16", longint'(b16.Done), 0);
      check("rst_prod16", get_prod(1'b1), 0);
      reset = 1'b1;

      foreach (vecs[i]) begin
         run_op(1'b0, vecs[i].m, vecs[i].q, 0, p, lat);
         check($sformatf("vec%0d_product", i), p, vecs[i].exp_p);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      end

      run_op(1'b1, -5, 1234, 5, p, lat);
      check("w16_ignored_start_product", p, -6170);
      check("w16_latency", lat, 18);

      @(negedge clk);
      drive(1'b0, 1'b1, 3, -4);
      ndone = 0;
      last  = 0;
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         if (i == 33) drive(1'b0, 1'b0, 3, -4);
         if (b8.Done) begin
            ndone++;
            check("held_interval", i - last, (ndone == 1) ? 10 : 11);
            check("held_product", get_prod(1'b0), -12);
            last = i;
         end
      end
      check("held_done_count", ndone, 3);
      @(negedge clk);
      check("held_idle_after", get_ready(1'b0), 1);

      drive(1'b0, 1'b1, 9, 9);
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         drive(1'b0, 1'b0, 9, 9);
      end
      reset = 1'b0;
      #1;
      check("abort_ready", get_ready(1'b0), 1);
      check("abort_done", longint'(b8.Done), 0);
      check("abort_product", get_prod(1'b0), 0);
      @(negedge clk);
      reset = 1'b1;
      ndone = 0;
      repeat (15) begin
         @(negedge clk);
         if (b8.Done) ndone++;
      end
      check("abort_no_done", ndone, 0);
      run_op(1'b0, 2, -3, 0, p, lat);
      check("after_abort_product", p, -6);
      check("after_abort_latency", lat, 10);

      for (int i = 0; i < 30; i++) begin
         w = 1'($urandom_range(0, 1));
         r = int'($urandom);
         m = w ? longint'($signed(r[15:0])) : longint'($signed(r[7:0]));
         r = int'($urandom);
         q = w ? longint'($signed(r[15:0])) : longint'($signed(r[7:0]));
         sel = int'($urandom_range(0, 5));
         if (sel == 0) m = 0;
         if (sel == 1) q = 0;
         if (sel == 2) m = w ? -32768 : -128;
         if (sel == 3) q = w ? -32768 : -128;
         run_op(w, m, q, 0, p, lat);
         check($sformatf("rand%0d_product m=%0d q=%0d", i, m, q), p, m * q);
         check($sformatf("rand%0d_latency", i), lat, exp_lat(w, m, q));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/booth_sequencer.md
Name: booth_sequencer

Overview:
- Sequential radix-2 Booth signed multiplier.
- An FSM sequences one add/subtract-and-shift step per clock over a shared adder, using Multiplexer2to1 instances for operand and register-load selection.
- Sits between the operand registers and the result consumer, with a Start/Ready/Done handshake.
- One multiplication in flight at a time.

Parameters:
- NBits, 16, operand width in bits (two's complement); minimum 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- Start  input  1  request a multiplication; sampled only while Ready=1.
- Multiplicand  input  NBits  signed operand M; captured on accepted Start.
- Multiplier  input  NBits  signed operand Q; captured on accepted Start.
- Ready  output  1  high in IDLE; block can accept Start.
- Done  output  1  one-cycle pulse when Product becomes valid.
- Product  output  2*NBits  signed result M*Q; holds until the next accepted Start.

Behaviour:
- Reset (async, reset==0):
  - State=IDLE, Ready=1, Done=0, Product=0.
  - Internal A, Q, Q_1 and iteration counter are cleared.
  - Reset mid-operation aborts immediately; no Done is produced.
- States:
  - IDLE: Ready=1. Start=1 -> LOAD. Operands are registered on this edge (cycle 0).
  - LOAD (cycle 1):
    - A (NBits+1 bits) <= 0, Q <= Multiplier, Q_1 <= 0.
    - M is sign-extended to NBits+1 bits; Count <= NBits.
    - -> ITER.
  - ITER (cycles 2..NBits+1), one step per cycle:
    - Booth pair {Q[0],Q_1}: 10 -> A-M; 01 -> A+M; 00/11 -> A unchanged.
    - Then arithmetic shift right of {A,Q,Q_1} by one; Count decrements.
    - When Count reaches 1 on this step -> DONE.
  - DONE (cycle NBits+2):
    - Product <= low 2*NBits bits of {A,Q}; Done=1 for exactly this cycle.
    - -> IDLE.
- Latency: accepted Start to Done is NBits+2 cycles. Back-to-back throughput is one result per NBits+3 cycles.
- Start while Ready=0 is ignored, not queued. Operand changes after capture have no effect.
- Start held high continuously: a new operation is accepted on the first IDLE cycle after DONE.
- Width rule:
  - A carries one guard bit, so M = -2^(NBits-1) cannot overflow.
  - Result is exact for all operand pairs, including (-2^(NBits-1)) × (-2^(NBits-1)) = +2^(2*NBits-2).
- Ready is combinational from state. Done and Product are registered.

Optional Feature:
- Macro: BOOTH_ZERO_SKIP_EN.
- Defined:
  - In LOAD, if the captured Multiplicand==0 or Multiplier==0, go directly to DONE with Product=0.
  - Done then occurs at cycle 2 after Start.
  - Nonzero operands behave exactly as in the base design.
- Undefined: all operations take NBits+2 cycles regardless of operand values.

Decomposition:
- Package booth_pkg:
  - typedef enum state_t {IDLE, LOAD, ITER, DONE};
  - typedef enum booth_op_t {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB};
  - function decode_booth_pair(q0, q_1) returns booth_op_t.
- Sub-module booth_step (combinational):
  - Takes A, Q, Q_1, M and op; returns the shifted {A,Q,Q_1}.
  - Selects +M/-M using Multiplexer2to1 (NBits+1) and the shift-vs-load source using a second Multiplexer2to1.
- booth_sequencer holds the FSM, counter and registers.

Test Plan:
- NBits=8; Start with M=7, Q=3 -> Done exactly 10 cycles later, Product=21. Ready low from cycle 1 through DONE.
- NBits=8; M=-128, Q=-128 -> Product=16384 (0x4000). M=-128, Q=127 -> Product=-16256 (0xC080).
- NBits=16; M=-5, Q=1234 -> Product=-6170. A Start pulse at cycle 5 with other operands is ignored, and the result still equals -6170.
- NBits=8; reset asserted at cycle 4 of an operation with M=9, Q=9 -> Ready=1, Product=0, no Done. A new Start with M=2, Q=-3 -> Product=-6.
- NBits=8; Start held high with constant M=3, Q=-4 -> Done every 11 cycles, Product=-12 each time.
- BOOTH_ZERO_SKIP_EN defined, NBits=8; M=0, Q=-77 -> Done 2 cycles after Start, Product=0. M=5, Q=6 -> Product=30 after 10 cycles.
